// File: rtl/parking_gate_scheduler.sv
// Shared barrier gate sequencer: arbitrates entrance/exit lanes, runs the password
// handshake for entries, times the gate-open window and tracks lot occupancy.
module parking_gate_scheduler #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned OPEN_CYCLES = 50,
    parameter int unsigned PW_TIMEOUT  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pw_valid,
    input  logic             pw_ok,
    output logic             grant_entry,
    output logic             gate_open,
    output logic             green_led,
    output logic             red_led,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam int unsigned TMax   = (OPEN_CYCLES > PW_TIMEOUT) ? OPEN_CYCLES : PW_TIMEOUT;
    localparam int unsigned TimerW = $clog2(TMax + 1);

    localparam logic [TimerW-1:0] OpenLast = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] AuthLast = TimerW'(PW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CapVal   = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        StIdle,
        StEntryAuth,
        StEntryOpen,
        StExitOpen,
        StWaitClear
    } state_e;

    state_e            state_q;
    logic [TimerW-1:0] timer_q;
    logic              rr_exit_q;      // 1: exit lane won the last arbitration
    logic              served_exit_q;  // lane whose sensor WAIT_CLEAR watches
    logic              grant_q;
    logic              gate_q;
    logic              red_q;
    logic              full_q;
    logic              empty_q;
    logic [CNT_W-1:0]  occ_q;

    logic             entry_elig;
    logic             exit_elig;
    logic             pick_entry;
    logic             pick_exit;
    logic             clear_req;
    logic [CNT_W-1:0] occ_inc;
    logic [CNT_W-1:0] occ_dec;

    // Lane eligibility and round-robin winner selection for IDLE.
    always_comb begin
        entry_elig = entry_req && !full_q;
        exit_elig  = exit_req && !empty_q;
        // On a tie the lane opposite the previous winner is served.
        pick_entry = entry_elig && (!exit_elig || rr_exit_q);
        pick_exit  = exit_elig && !pick_entry;
        clear_req  = served_exit_q ? exit_req : entry_req;
        occ_inc    = occ_q + CNT_W'(1);
        occ_dec    = occ_q - CNT_W'(1);
    end

    // Gate FSM with registered outputs, timer and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            rr_exit_q     <= 1'b1;
            served_exit_q <= 1'b0;
            grant_q       <= 1'b0;
            gate_q        <= 1'b0;
            red_q         <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            occ_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    if (pick_entry) begin
                        state_q       <= StEntryAuth;
                        grant_q       <= 1'b1;
                        red_q         <= 1'b0;
                        rr_exit_q     <= 1'b0;
                        served_exit_q <= 1'b0;
                    end else if (pick_exit) begin
                        state_q       <= StExitOpen;
                        gate_q        <= 1'b1;
                        red_q         <= 1'b0;
                        rr_exit_q     <= 1'b1;
                        served_exit_q <= 1'b1;
                        occ_q         <= occ_dec;
                        full_q        <= 1'b0;
                        empty_q       <= (occ_dec == '0);
                    end else begin
                        red_q <= full_q;
                    end
                end
                StEntryAuth: begin
                    // A correct password wins even on the final timeout cycle.
                    if (pw_valid && pw_ok) begin
                        state_q <= StEntryOpen;
                        grant_q <= 1'b0;
                        gate_q  <= 1'b1;
                        red_q   <= 1'b0;
                        timer_q <= '0;
                        occ_q   <= occ_inc;
                        empty_q <= 1'b0;
                        full_q  <= (occ_inc == CapVal);
                    end else if (timer_q == AuthLast) begin
                        state_q <= StIdle;
                        grant_q <= 1'b0;
                        red_q   <= full_q;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                        if (pw_valid) begin
                            red_q <= 1'b1;
                        end
                    end
                end
                StEntryOpen, StExitOpen: begin
                    if (timer_q == OpenLast) begin
                        state_q <= StWaitClear;
                        gate_q  <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StWaitClear: begin
                    // Hold until the served car has left the sensor.
                    if (!clear_req) begin
                        state_q <= StIdle;
                        red_q   <= full_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant_entry = grant_q;
    assign gate_open   = gate_q;
    assign green_led   = gate_q;
    assign red_led     = red_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Bench for parking_gate_scheduler: directed scenarios plus randomized traffic, all checked
// every cycle against a phase/countdown model of the gate behaviour.
module tb_parking_gate_scheduler;

    localparam int CAP  = 8;
    localparam int OPEN = 50;
    localparam int PWT  = 100;

    localparam int P_IDLE = 0;
    localparam int P_AUTH = 1;
    localparam int P_IN   = 2;
    localparam int P_OUT  = 3;
    localparam int P_WAIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       pw_valid;
    logic       pw_ok;
    logic       grant_entry;
    logic       gate_open;
    logic       green_led;
    logic       red_led;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: current phase, cycles left in a timed phase, car count, tie-break memory,
    // served lane, and wrong-password flag.
    int m_phase = P_IDLE;
    int m_left  = 0;
    int m_occ   = 0;
    bit m_rr_exit   = 1'b1;
    bit m_lane_exit = 1'b0;
    bit m_bad       = 1'b0;

    always #5 clk = ~clk;

    parking_gate_scheduler #(
        .CAPACITY   (CAP),
        .CNT_W      (4),
        .OPEN_CYCLES(OPEN),
        .PW_TIMEOUT (PWT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .pw_valid   (pw_valid),
        .pw_ok      (pw_ok),
        .grant_entry(grant_entry),
        .gate_open  (gate_open),
        .green_led  (green_led),
        .red_led    (red_led),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_step();
        bit e;
        bit x;
        if (reset) begin
            m_phase   = P_IDLE;
            m_left    = 0;
            m_occ     = 0;
            m_rr_exit = 1'b1;
            m_bad     = 1'b0;
            chk_en    = 1'b1;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                e = entry_req && (m_occ < CAP);
                x = exit_req && (m_occ > 0);
                if (e && x) begin
                    if (m_rr_exit) x = 1'b0;
                    else e = 1'b0;
                end
                if (e) begin
                    m_phase   = P_AUTH;
                    m_left    = PWT;
                    m_bad     = 1'b0;
                    m_rr_exit = 1'b0;
                end else if (x) begin
                    m_phase     = P_OUT;
                    m_left      = OPEN;
                    m_occ       = m_occ - 1;
                    m_rr_exit   = 1'b1;
                    m_lane_exit = 1'b1;
                end
            end
            P_AUTH: begin
                if (pw_valid && pw_ok) begin
                    m_phase     = P_IN;
                    m_left      = OPEN;
                    m_occ       = m_occ + 1;
                    m_lane_exit = 1'b0;
                    m_bad       = 1'b0;
                end else begin
                    if (pw_valid) m_bad = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_IDLE;
                        m_bad   = 1'b0;
                    end
                end
            end
            P_IN, P_OUT: begin
                m_left--;
                if (m_left == 0) m_phase = P_WAIT;
            end
            default: begin
                if (!(m_lane_exit ? exit_req : entry_req)) m_phase = P_IDLE;
            end
        endcase
    endtask

    // Every cycle after the first reset edge: all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("grant_entry", int'(grant_entry), (m_phase == P_AUTH) ? 1 : 0);
            check("gate_open", int'(gate_open), (m_phase == P_IN || m_phase == P_OUT) ? 1 : 0);
            check("green_led", int'(green_led), (m_phase == P_IN || m_phase == P_OUT) ? 1 : 0);
            check("red_led", int'(red_led),
                  (m_phase == P_IDLE) ? ((m_occ == CAP) ? 1 : 0) :
                  (m_phase == P_AUTH) ? int'(m_bad) : 0);
            check("occupancy", int'(occupancy), m_occ);
            check("full", int'(full), (m_occ == CAP) ? 1 : 0);
            check("empty", int'(empty), (m_occ == 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && m_phase != P_IDLE; k++) tick();
        check("wait_idle_bound", m_phase, P_IDLE);
    endtask

    task automatic do_entry();
        entry_req = 1'b1;
        tick();
        pw_valid = 1'b1;
        pw_ok    = 1'b1;
        tick();
        pw_valid  = 1'b0;
        entry_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        int cnt;
        bit saw_gate;
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        pw_valid  = 1'b0;
        pw_ok     = 1'b0;
        repeat (5) tick();
        check("reset_empty", int'(empty), 1);
        check("reset_occ", int'(occupancy), 0);
        reset = 1'b0;

        // 1: correct password on the third AUTH cycle.
        entry_req = 1'b1;
        tick();
        check("t1_grant", int'(grant_entry), 1);
        tick();
        tick();
        pw_valid = 1'b1;
        pw_ok    = 1'b1;
        tick();
        pw_valid = 1'b0;
        check("t1_occ", int'(occupancy), 1);
        check("t1_empty", int'(empty), 0);
        cnt = 0;
        while (gate_open && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t1_gate_cycles", cnt, 50);
        entry_req = 1'b0;
        wait_idle();

        // 2: wrong password, then correct.
        entry_req = 1'b1;
        tick();
        pw_valid = 1'b1;
        pw_ok    = 1'b0;
        tick();
        pw_valid = 1'b0;
        check("t2_red_after_bad", int'(red_led), 1);
        check("t2_still_auth", int'(grant_entry), 1);
        pw_valid = 1'b1;
        pw_ok    = 1'b1;
        tick();
        pw_valid = 1'b0;
        check("t2_red_cleared", int'(red_led), 0);
        check("t2_gate", int'(gate_open), 1);
        check("t2_occ", int'(occupancy), 2);
        entry_req = 1'b0;
        wait_idle();

        // 3: password timeout.
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        cnt = 0;
        saw_gate = 1'b0;
        while (grant_entry && cnt < 200) begin
            cnt++;
            saw_gate |= gate_open;
            tick();
        end
        check("t3_auth_cycles", cnt, 100);
        check("t3_gate_never", int'(saw_gate), 0);
        check("t3_occ", int'(occupancy), 2);

        // 4: fill the lot; entry ignored, exit served.
        repeat (6) do_entry();
        check("t4_full", int'(full), 1);
        check("t4_red", int'(red_led), 1);
        entry_req = 1'b1;
        repeat (3) begin
            tick();
            check("t4_entry_ignored", int'(grant_entry), 0);
        end
        exit_req = 1'b1;
        tick();
        check("t4_exit_gate", int'(gate_open), 1);
        check("t4_occ7", int'(occupancy), 7);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        wait_idle();

        // 5: occupancy 3 with entry as last winner; both lanes requesting.
        repeat (5) do_exit();
        do_entry();
        check("t5_occ3", int'(occupancy), 3);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        check("t5_exit_first", int'(gate_open), 1);
        check("t5_no_grant", int'(grant_entry), 0);
        check("t5_occ2", int'(occupancy), 2);
        repeat (OPEN) tick();
        exit_req = 1'b0;
        tick();
        tick();
        check("t5_entry_next", int'(grant_entry), 1);
        pw_valid = 1'b1;
        pw_ok    = 1'b1;
        tick();
        pw_valid  = 1'b0;
        entry_req = 1'b0;
        wait_idle();
        check("t5_final_occ", int'(occupancy), 3);

        // 6: reset during the open window.
        entry_req = 1'b1;
        tick();
        pw_valid = 1'b1;
        pw_ok    = 1'b1;
        tick();
        pw_valid = 1'b0;
        repeat (19) tick();
        check("t6_open_c20", int'(gate_open), 1);
        reset = 1'b1;
        tick();
        check("t6_gate_closed", int'(gate_open), 0);
        check("t6_occ", int'(occupancy), 0);
        check("t6_empty", int'(empty), 1);
        reset     = 1'b0;
        entry_req = 1'b0;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) entry_req = ~entry_req;
            if ($urandom_range(0, 7) == 0) exit_req = ~exit_req;
            pw_valid = ($urandom_range(0, 6) == 0);
            pw_ok    = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
